// File: rtl/edge_wave_scheduler_pkg.sv
// Shared types and derived-constant helpers for the edge wave scheduler.
// Edge words are packed {dst, src} with src in the low NODE_W bits.
package gnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    DONE
  } sched_state_e;

  localparam int EDGE_MAX_W = 32;

  function automatic int calc_chunks(input int feat_dim, input int lanes);
    return feat_dim / lanes;
  endfunction

  function automatic int calc_waves(input int chunks, input int num_cores);
    return (chunks + num_cores - 1) / num_cores;
  endfunction

  function automatic int calc_fw(input int feat_dim);
    int w;
    w = $clog2(feat_dim);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [EDGE_MAX_W-1:0] edge_src(input logic [2*EDGE_MAX_W-1:0] word,
                                                     input int node_w);
    logic [2*EDGE_MAX_W-1:0] mask;
    mask = (64'd1 << node_w) - 64'd1;
    return EDGE_MAX_W'(word & mask);
  endfunction

  function automatic logic [EDGE_MAX_W-1:0] edge_dst(input logic [2*EDGE_MAX_W-1:0] word,
                                                     input int node_w);
    logic [2*EDGE_MAX_W-1:0] mask;
    mask = (64'd1 << node_w) - 64'd1;
    return EDGE_MAX_W'((word >> node_w) & mask);
  endfunction

endpackage

// File: rtl/edge_wave_scheduler_if.sv
// Wave dispatch handshake between the scheduler and the SIMD dispatch stage.
interface edge_wave_scheduler_if #(
  parameter int NUM_CORES = 64,
  parameter int NODE_W    = 12,
  parameter int FW        = 8
);
  logic                 wave_valid;
  logic                 wave_ready;
  logic [NODE_W-1:0]    wave_src;
  logic [NODE_W-1:0]    wave_dst;
  logic [NUM_CORES-1:0] wave_core_en;
  logic [FW-1:0]        wave_feat_start;
  logic [FW-1:0]        wave_feat_stop;
  logic                 wave_last;

  modport master (
    output wave_valid, wave_src, wave_dst, wave_core_en,
           wave_feat_start, wave_feat_stop, wave_last,
    input  wave_ready
  );

  modport slave (
    input  wave_valid, wave_src, wave_dst, wave_core_en,
           wave_feat_start, wave_feat_stop, wave_last,
    output wave_ready
  );
endinterface

// File: rtl/edge_wave_scheduler_wave_mask_gen.sv
// Combinational decode of a wave index into its core mask and element range.
module wave_mask_gen
  import gnn_sched_pkg::*;
#(
  parameter  int NUM_CORES = 64,
  parameter  int FEAT_DIM  = 256,
  parameter  int LANES     = 4,
  localparam int CHUNKS    = calc_chunks(FEAT_DIM, LANES),
  localparam int WAVES     = calc_waves(CHUNKS, NUM_CORES),
  localparam int FW        = calc_fw(FEAT_DIM),
  localparam int WI        = calc_fw(WAVES)
) (
  input  logic [WI-1:0]        wave_idx,
  output logic [NUM_CORES-1:0] core_en,
  output logic [FW-1:0]        feat_start,
  output logic [FW-1:0]        feat_stop,
  output logic                 last
);

  always_comb begin
    int rem;
    int n;
    int lo;
    int hi;
    rem = CHUNKS - int'(wave_idx) * NUM_CORES;
    n   = (rem < NUM_CORES) ? rem : NUM_CORES;
    core_en = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (i < n) core_en[i] = 1'b1;
    end
    lo = int'(wave_idx) * NUM_CORES * LANES;
    hi = lo + NUM_CORES * LANES;
    if (hi > FEAT_DIM) hi = FEAT_DIM;
    feat_start = FW'(lo);
    feat_stop  = FW'(hi - 1);
    last       = (int'(wave_idx) == WAVES - 1);
  end

endmodule

// File: rtl/edge_wave_scheduler.sv
// Walks a block of the edge table and issues each edge as one or more
// feature-chunk waves to the SIMD core bank, optionally dropping self-loops.
module edge_wave_scheduler
  import gnn_sched_pkg::*;
#(
  parameter int NUM_CORES = 64,
  parameter int NODE_W    = 12,
  parameter int EDGE_AW   = 5,
  parameter int FEAT_DIM  = 256,
  parameter int LANES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [EDGE_AW-1:0]    base_addr,
  input  logic [EDGE_AW:0]      num_edges,
  input  logic                  skip_self,
  output logic                  busy,
  output logic                  done,
  output logic [EDGE_AW:0]      skip_count,
  output logic                  edge_rd_en,
  output logic [EDGE_AW-1:0]    edge_addr,
  input  logic [2*NODE_W-1:0]   edge_data,
  edge_wave_scheduler_if.master wave
);

  localparam int CHUNKS = calc_chunks(FEAT_DIM, LANES);
  localparam int WAVES  = calc_waves(CHUNKS, NUM_CORES);
  localparam int FW     = calc_fw(FEAT_DIM);
  localparam int WI     = calc_fw(WAVES);

  sched_state_e         state_q, state_d;
  logic [EDGE_AW-1:0]   base_q;
  logic [EDGE_AW:0]     num_q;
  logic                 skip_q;
  logic [EDGE_AW:0]     edge_idx_q;
  logic [EDGE_AW:0]     skip_cnt_q;
  logic [WI-1:0]        wave_idx_q;
  logic [NODE_W-1:0]    src_q, dst_q;
  logic [NODE_W-1:0]    src_now, dst_now;
  logic                 is_self, last_edge, hs, issuing;
  logic [NUM_CORES-1:0] m_core_en;
  logic [FW-1:0]        m_start, m_stop;
  logic                 m_last;

  wave_mask_gen #(
    .NUM_CORES(NUM_CORES),
    .FEAT_DIM (FEAT_DIM),
    .LANES    (LANES)
  ) u_mask (
    .wave_idx  (wave_idx_q),
    .core_en   (m_core_en),
    .feat_start(m_start),
    .feat_stop (m_stop),
    .last      (m_last)
  );

  assign src_now   = NODE_W'(edge_src(64'(edge_data), NODE_W));
  assign dst_now   = NODE_W'(edge_dst(64'(edge_data), NODE_W));
  assign is_self   = skip_q && (src_now == dst_now);
  assign last_edge = ((edge_idx_q + 1'b1) == num_q);
  assign issuing   = (state_q == ISSUE);
  assign hs        = issuing && wave.wave_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_edges == '0) ? DONE : FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    if (is_self) state_d = last_edge ? DONE : FETCH;
               else         state_d = ISSUE;
      ISSUE:   if (hs && m_last) state_d = last_edge ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      skip_q     <= 1'b0;
      edge_idx_q <= '0;
      skip_cnt_q <= '0;
      wave_idx_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          base_q     <= base_addr;
          num_q      <= num_edges;
          skip_q     <= skip_self;
          skip_cnt_q <= '0;
          edge_idx_q <= '0;
        end
        WAIT: begin
          src_q      <= src_now;
          dst_q      <= dst_now;
          wave_idx_q <= '0;
          if (is_self) begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
            edge_idx_q <= edge_idx_q + 1'b1;
          end
        end
        ISSUE: if (hs) begin
          if (m_last) edge_idx_q <= edge_idx_q + 1'b1;
          else        wave_idx_q <= wave_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign skip_count = skip_cnt_q;
  assign edge_rd_en = (state_q == FETCH);
  assign edge_addr  = base_q + edge_idx_q[EDGE_AW-1:0];

  // Wave fields are forced to zero outside ISSUE so idle/reset outputs read as 0.
  assign wave.wave_valid      = issuing;
  assign wave.wave_src        = issuing ? src_q : '0;
  assign wave.wave_dst        = issuing ? dst_q : '0;
  assign wave.wave_core_en    = issuing ? m_core_en : '0;
  assign wave.wave_feat_start = issuing ? m_start : '0;
  assign wave.wave_feat_stop  = issuing ? m_stop : '0;
  assign wave.wave_last       = issuing && m_last;

endmodule

// File: tb/tb_edge_wave_scheduler.sv
// Directed bench: default config (1 wave/edge) and a 16-core/200-element
// config (4 waves/edge) driven side by side from behavioural edge RAMs.
module tb_edge_wave_scheduler;
  import gnn_sched_pkg::*;

  localparam int NODE_W  = 12;
  localparam int EDGE_AW = 5;
  localparam int LANES   = 4;
  localparam int NC0 = 64, FD0 = 256;
  localparam int NC1 = 16, FD1 = 200;
  localparam int FW0 = calc_fw(FD0);
  localparam int FW1 = calc_fw(FD1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 start0, skip0, busy0, done0, rd0;
  logic [EDGE_AW-1:0]   base0, addr0;
  logic [EDGE_AW:0]     num0, skc0;
  logic [2*NODE_W-1:0]  data0 = '0;
  logic [2*NODE_W-1:0]  ram0 [32];

  logic                 start1, skip1, busy1, done1, rd1;
  logic [EDGE_AW-1:0]   base1, addr1;
  logic [EDGE_AW:0]     num1, skc1;
  logic [2*NODE_W-1:0]  data1 = '0;
  logic [2*NODE_W-1:0]  ram1 [32];

  edge_wave_scheduler_if #(.NUM_CORES(NC0), .NODE_W(NODE_W), .FW(FW0)) w0 ();
  edge_wave_scheduler_if #(.NUM_CORES(NC1), .NODE_W(NODE_W), .FW(FW1)) w1 ();

  edge_wave_scheduler #(.NUM_CORES(NC0), .NODE_W(NODE_W), .EDGE_AW(EDGE_AW),
                        .FEAT_DIM(FD0), .LANES(LANES)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .num_edges(num0),
    .skip_self(skip0), .busy(busy0), .done(done0), .skip_count(skc0),
    .edge_rd_en(rd0), .edge_addr(addr0), .edge_data(data0), .wave(w0.master)
  );

  edge_wave_scheduler #(.NUM_CORES(NC1), .NODE_W(NODE_W), .EDGE_AW(EDGE_AW),
                        .FEAT_DIM(FD1), .LANES(LANES)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .base_addr(base1), .num_edges(num1),
    .skip_self(skip1), .busy(busy1), .done(done1), .skip_count(skc1),
    .edge_rd_en(rd1), .edge_addr(addr1), .edge_data(data1), .wave(w1.master)
  );

  always @(posedge clk) if (rd0) data0 <= ram0[addr0];
  always @(posedge clk) if (rd1) data1 <= ram1[addr1];

  int hs1_cnt = 0;
  always @(posedge clk) if (w1.wave_valid && w1.wave_ready) hs1_cnt <= hs1_cnt + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start0_job(input logic [EDGE_AW-1:0] b, input logic [EDGE_AW:0] n, input logic s);
    base0 = b; num0 = n; skip0 = s; start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic start1_job(input logic [EDGE_AW-1:0] b, input logic [EDGE_AW:0] n, input logic s);
    base1 = b; num1 = n; skip1 = s; start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  logic [15:0] en_tab [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003};
  int          st_tab [4] = '{0, 64, 128, 192};
  int          sp_tab [4] = '{63, 127, 191, 199};
  int          pre;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    start0 = 0; skip0 = 0; base0 = '0; num0 = '0;
    start1 = 0; skip1 = 0; base1 = '0; num1 = '0;
    w0.wave_ready = 1'b1;
    w1.wave_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ram0[i] = {12'd100, 12'd101};
      ram1[i] = {12'd100, 12'd101};
    end
    ram0[0]  = {12'd5, 12'd3};
    ram0[1]  = {12'd9, 12'd7};
    ram0[4]  = {12'd4, 12'd4};
    ram0[5]  = {12'd2, 12'd6};
    ram0[6]  = {12'd8, 12'd8};
    ram0[31] = {12'd1, 12'd2};
    ram1[0]  = {12'd11, 12'd10};
    ram1[1]  = {12'd21, 12'd20};

    // reset state
    repeat (3) tick();
    chk("rst_busy",    64'(busy0), 64'd0);
    chk("rst_done",    64'(done0), 64'd0);
    chk("rst_rd",      64'(rd0), 64'd0);
    chk("rst_addr",    64'(addr0), 64'd0);
    chk("rst_valid",   64'(w0.wave_valid), 64'd0);
    chk("rst_core_en", 64'(w0.wave_core_en), 64'd0);
    chk("rst_stop",    64'(w0.wave_feat_stop), 64'd0);
    chk("rst_skc",     64'(skc0), 64'd0);
    rst = 1'b1;
    tick();

    // two single-wave edges, ready high
    start0_job(5'd0, 6'd2, 1'b0);
    chk("t1_busy",  64'(busy0), 64'd1);
    chk("t1_rd0",   64'(rd0), 64'd1);
    chk("t1_addr0", 64'(addr0), 64'd0);
    tick();
    chk("t1_wait_valid", 64'(w0.wave_valid), 64'd0);
    tick();
    chk("t1_valid0", 64'(w0.wave_valid), 64'd1);
    chk("t1_en0",    64'(w0.wave_core_en), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_start0", 64'(w0.wave_feat_start), 64'd0);
    chk("t1_stop0",  64'(w0.wave_feat_stop), 64'd255);
    chk("t1_last0",  64'(w0.wave_last), 64'd1);
    chk("t1_src0",   64'(w0.wave_src), 64'd3);
    chk("t1_dst0",   64'(w0.wave_dst), 64'd5);
    tick();
    chk("t1_rd1",    64'(rd0), 64'd1);
    chk("t1_addr1",  64'(addr0), 64'd1);
    chk("t1_gap_valid", 64'(w0.wave_valid), 64'd0);
    tick();
    tick();
    chk("t1_valid1", 64'(w0.wave_valid), 64'd1);
    chk("t1_src1",   64'(w0.wave_src), 64'd7);
    chk("t1_dst1",   64'(w0.wave_dst), 64'd9);
    chk("t1_early_done", 64'(done0), 64'd0);
    tick();
    chk("t1_done",   64'(done0), 64'd1);
    chk("t1_valid_after", 64'(w0.wave_valid), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done0), 64'd0);
    chk("t1_idle_busy",  64'(busy0), 64'd0);

    // one edge split into four waves
    start1_job(5'd0, 6'd1, 1'b0);
    pre = hs1_cnt;
    tick();
    tick();
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("t2_valid%0d", w), 64'(w1.wave_valid), 64'd1);
      chk($sformatf("t2_en%0d", w),    64'(w1.wave_core_en), 64'(en_tab[w]));
      chk($sformatf("t2_start%0d", w), 64'(w1.wave_feat_start), 64'(st_tab[w]));
      chk($sformatf("t2_stop%0d", w),  64'(w1.wave_feat_stop), 64'(sp_tab[w]));
      chk($sformatf("t2_last%0d", w),  64'(w1.wave_last), (w == 3) ? 64'd1 : 64'd0);
      chk($sformatf("t2_src%0d", w),   64'(w1.wave_src), 64'd10);
      tick();
    end
    chk("t2_done", 64'(done1), 64'd1);
    chk("t2_hs",   64'(hs1_cnt - pre), 64'd4);
    tick();

    // backpressure on the second wave
    start1_job(5'd1, 6'd1, 1'b0);
    pre = hs1_cnt;
    tick();
    tick();
    chk("bp_start0", 64'(w1.wave_feat_start), 64'd0);
    tick();
    chk("bp_start1", 64'(w1.wave_feat_start), 64'd64);
    w1.wave_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", k), 64'(w1.wave_valid), 64'd1);
      chk($sformatf("bp_hold_start%0d", k), 64'(w1.wave_feat_start), 64'd64);
      chk($sformatf("bp_hold_en%0d", k),    64'(w1.wave_core_en), 64'hFFFF);
      chk($sformatf("bp_hold_src%0d", k),   64'(w1.wave_src), 64'd20);
    end
    w1.wave_ready = 1'b1;
    tick();
    chk("bp_start2", 64'(w1.wave_feat_start), 64'd128);
    tick();
    chk("bp_start3", 64'(w1.wave_feat_start), 64'd192);
    chk("bp_last3",  64'(w1.wave_last), 64'd1);
    tick();
    chk("bp_done", 64'(done1), 64'd1);
    chk("bp_hs",   64'(hs1_cnt - pre), 64'd4);
    tick();

    // self-loop skipping
    start0_job(5'd4, 6'd3, 1'b1);
    chk("sk_addr4", 64'(addr0), 64'd4);
    tick();
    tick();
    chk("sk_rd5",   64'(rd0), 64'd1);
    chk("sk_addr5", 64'(addr0), 64'd5);
    chk("sk_cnt1",  64'(skc0), 64'd1);
    tick();
    tick();
    chk("sk_valid", 64'(w0.wave_valid), 64'd1);
    chk("sk_src",   64'(w0.wave_src), 64'd6);
    chk("sk_dst",   64'(w0.wave_dst), 64'd2);
    tick();
    chk("sk_addr6", 64'(addr0), 64'd6);
    tick();
    tick();
    chk("sk_done",  64'(done0), 64'd1);
    chk("sk_cnt2",  64'(skc0), 64'd2);
    tick();
    chk("sk_hold",  64'(skc0), 64'd2);

    // empty job
    start0_job(5'd7, 6'd0, 1'b0);
    chk("z_done",    64'(done0), 64'd1);
    chk("z_rd",      64'(rd0), 64'd0);
    chk("z_skc_clr", 64'(skc0), 64'd0);
    tick();
    chk("z_done_pulse", 64'(done0), 64'd0);

    // address wrap
    start0_job(5'd31, 6'd2, 1'b0);
    chk("wr_addr31", 64'(addr0), 64'd31);
    tick();
    tick();
    chk("wr_src0", 64'(w0.wave_src), 64'd2);
    tick();
    chk("wr_addr0", 64'(addr0), 64'd0);
    tick();
    tick();
    chk("wr_src1", 64'(w0.wave_src), 64'd3);
    tick();
    chk("wr_done", 64'(done0), 64'd1);
    tick();

    // reset while a wave is stalled
    w1.wave_ready = 1'b0;
    start1_job(5'd0, 6'd1, 1'b0);
    tick();
    tick();
    chk("rs_valid_pre", 64'(w1.wave_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("rs_valid_async", 64'(w1.wave_valid), 64'd0);
    tick();
    chk("rs_valid", 64'(w1.wave_valid), 64'd0);
    chk("rs_en",    64'(w1.wave_core_en), 64'd0);
    chk("rs_busy",  64'(busy1), 64'd0);
    chk("rs_rd",    64'(rd1), 64'd0);
    rst = 1'b1;
    w1.wave_ready = 1'b1;
    tick();
    start1_job(5'd0, 6'd1, 1'b0);
    tick();
    tick();
    chk("rs2_valid", 64'(w1.wave_valid), 64'd1);
    chk("rs2_en",    64'(w1.wave_core_en), 64'hFFFF);
    chk("rs2_start", 64'(w1.wave_feat_start), 64'd0);
    chk("rs2_src",   64'(w1.wave_src), 64'd10);
    repeat (3) tick();
    chk("rs2_last",  64'(w1.wave_last), 64'd1);
    tick();
    chk("rs2_done",  64'(done1), 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
